sha512_msg_pack: RTL and testbench
==================================

Name: sha512_msg_pack

Overview:
- Write-side front end of the SHA-512 message FIFO.
- Accepts byte-strobed 32-bit message writes from the register/DMA path and packs them into big-endian 64-bit FIFO entries with a per-byte mask.
- Accumulates the message length in bits for the padding engine.
- On hash_process, flushes any residual bytes as one partial (masked) entry; the padder consumes that entry as its end-of-message marker.

Parameters:
- InW, 32, input write width in bits (multiple of 8, less than OutW).
- OutW, 64, FIFO entry width in bits (SHA-512 word).
- LenW, 128, message length counter width in bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset: one clock; reset is asynchronous and active-high
- sha_en  in  1  engine enable; low forces StIdle
- hash_start  in  1  start pulse; clears length and buffers
- hash_process  in  1  end-of-message pulse; triggers flush
- hash_done  in  1  digest complete; StDone to StIdle
- in_valid  in  1  write beat valid
- in_data  in  InW  write data; in_data[31:24] is the first message byte
- in_strb  in  InW/8  byte strobes; must be left-aligned contiguous (1111/1110/1100/1000/0000)
- in_ready  out  1  beat accepted when in_valid and in_ready
- fifo_wvalid  out  1  FIFO entry valid
- fifo_wdata  out  OutW  entry data, big-endian (first byte at [63:56])
- fifo_wmask  out  OutW/8  byte mask; bit 7 = [63:56]; partial only on flush
- fifo_wready  in  1  FIFO accepts entry
- message_length  out  LenW  accepted bytes x 8
- flush_done  out  1  one-cycle pulse when flush is complete
- err_strb  out  1  one-cycle pulse on an accepted beat with an illegal strobe

Behaviour:
- Reset values: all outputs 0, state StIdle, acc_cnt 0, out register empty.
- Datapath:
  - acc holds up to 7 pending bytes, left-aligned, with acc_cnt 0..7.
  - A single output register (ovalid, odata, omask) drives fifo_w*.
- Accept:
  - in_ready = (st==StPack) && (!ovalid || fifo_wready).
  - On accept with legal strobe (n = popcount 0..4): concatenate acc[0..acc_cnt-1] with the n new bytes, total t = acc_cnt+n (max 11).
  - If t>=8: first 8 bytes load the output register with omask=8'hFF and ovalid=1; the remaining t-8 bytes load acc.
  - Otherwise acc gets all t bytes. acc_cnt = t mod 8 in both cases.
  - message_length += 8*n (wraps modulo 2^LenW).
  - strb=0000 is legal with n=0: no change.
- Illegal strobe (any pattern not in the legal list):
  - Beat is consumed, data dropped, length unchanged.
  - err_strb pulses the next cycle.
- Output: ovalid clears on fifo_wready unless reloaded in the same cycle. Zero-bubble streaming: one entry per 2 full beats.
- States:
  - StIdle: in_ready=0. Moves to StPack on sha_en && hash_start; clears length, acc and out register.
  - StPack: accepts beats. On hash_process moves to StFlush; a beat accepted in that same cycle is included.
  - StFlush: in_ready=0. Waits for !ovalid.
    - If acc_cnt>0: loads the out register with data = acc zero-filled and mask = top acc_cnt bits set (e.g. cnt 3 gives 8'hE0), then waits for it to drain.
    - If acc_cnt==0: no entry is emitted.
    - When drained, pulses flush_done and moves to StDone.
  - StDone: in_ready=0; message_length holds. Moves to StIdle on hash_done. Moves to StPack with clear on hash_start.
- Boundary and priority rules:
  - hash_start in any state, with sha_en=1: synchronous restart to StPack. Acc, out register and length are cleared; a pending un-handshaked entry is dropped (fifo_wvalid=0 the next cycle).
  - sha_en=0 in any state: go to StIdle next cycle, buffers cleared, length held.
  - hash_process outside StPack: ignored.
  - Priority: rst_i > !sha_en > hash_start > hash_process > beat.
  - fifo_wvalid, once asserted, holds with stable data/mask until fifo_wready (except on restart/disable).
  - Asynchronous reset mid-operation returns everything to reset values; no partial entry is emitted.

Decomposition:
- Into hmac512_pkg: byte-count type, legal-strobe to count function (returns invalid flag), mask-from-count function, and the pack_st_e enum (StIdle, StPack, StFlush, StDone).
- One sub-module, sha512_byte_merge: combinational concatenate/split of acc plus the new bytes into {full word, remainder, new count}. The top level holds the FSM, registers and length counter.

Test Plan:
- Aligned: strb F, data 00010203, 04050607, 08090A0B, then hash_process -> entries 0001020304050607/FF and 08090A0B00000000/F0; message_length=96; flush_done once.
- Unaligned: C:AABB0000, F:11223344, F:55667788, process -> AABB112233445566/FF, then 7788000000000000/C0; length=80.
- Backpressure: fifo_wready=0 for 5 cycles while streaming F beats -> in_ready drops once the out register is full; entries unchanged and held; no byte lost or duplicated after release; length=8*bytes.
- Illegal strobe 0101 mid-stream -> err_strb pulse; length unchanged; subsequent packing continues as if the beat was absent.
- Exactly 16 bytes then hash_process -> two FF entries, no partial entry, flush_done pulses, state StDone until hash_done.
- hash_start while an entry is pending and acc_cnt=3 -> fifo_wvalid low next cycle, length=0, new stream packs from byte 0; assert rst_i mid-flush -> all outputs 0.

Source files
------------

// File: rtl/hmac512_pkg.sv
// Shared types and helpers for the SHA-512 message packer: byte counts,
// strobe decoding, partial-entry masks and the packer state encoding.
package hmac512_pkg;

    localparam int InWDef  = 32;
    localparam int OutWDef = 64;
    localparam int LenWDef = 128;
    localparam int InB     = InWDef / 8;
    localparam int OutB    = OutWDef / 8;

    typedef logic [3:0] cnt_t;

    typedef struct packed {
        logic invalid;
        cnt_t cnt;
    } strb_dec_t;

    typedef enum logic [1:0] {
        StIdle,
        StPack,
        StFlush,
        StDone
    } pack_st_e;

    // Only left-aligned contiguous strobes (including all-zero) are legal.
    function automatic strb_dec_t strb_decode(input logic [InB-1:0] strb);
        strb_dec_t dec;
        dec.invalid = 1'b1;
        dec.cnt     = '0;
        for (int k = 0; k <= InB; k++) begin
            if (strb == ~({InB{1'b1}} >> k)) begin
                dec.invalid = 1'b0;
                dec.cnt     = cnt_t'(k);
            end
        end
        return dec;
    endfunction

    function automatic logic [OutB-1:0] mask_from_cnt(input cnt_t cnt);
        return ~({OutB{1'b1}} >> cnt);
    endfunction

endpackage

// File: rtl/sha512_byte_merge.sv
// Appends the valid bytes of a write beat behind the pending bytes and splits
// the result into a full entry (when 8 or more bytes) and a left-aligned remainder.
module sha512_byte_merge
    import hmac512_pkg::*;
#(
    parameter int InW  = InWDef,
    parameter int OutW = OutWDef
) (
    input  logic [OutW-9:0] acc_i,
    input  logic [3:0]      acc_cnt_i,
    input  logic [InW-1:0]  data_i,
    input  logic [3:0]      n_i,
    output logic [OutW-1:0] word_o,
    output logic            full_o,
    output logic [OutW-9:0] rem_o,
    output logic [3:0]      cnt_o
);

    localparam int AccW  = OutW - 8;
    localparam int CatW  = AccW + InW;
    localparam int TailW = CatW - OutW;

    logic [InW-1:0]  data_keep;
    logic [CatW-1:0] cat;
    cnt_t            total;

    // acc_i is zero beyond its count, so OR-ing the shifted beat is a concatenation.
    assign data_keep = data_i & ~({InW{1'b1}} >> {n_i, 3'b000});
    assign cat       = {acc_i, {InW{1'b0}}} | ({data_keep, {AccW{1'b0}}} >> {acc_cnt_i, 3'b000});
    assign total     = acc_cnt_i + n_i;
    assign full_o    = (total >= cnt_t'(8));
    assign word_o    = cat[CatW-1 -: OutW];
    assign rem_o     = full_o ? {cat[TailW-1:0], {(AccW-TailW){1'b0}}} : cat[CatW-1 -: AccW];
    assign cnt_o     = full_o ? total - cnt_t'(8) : total;

endmodule

// File: rtl/sha512_msg_pack.sv
// Write-side front end of the SHA-512 message FIFO: packs byte-strobed beats into
// big-endian 64-bit entries, counts message bits, and flushes a masked tail entry.
//
// state   | meaning
// StIdle  | engine off, no beats accepted
// StPack  | accepting beats, emitting full entries
// StFlush | draining the out register, then emitting the partial tail entry
// StDone  | message closed, length held until hash_done or a new hash_start
module sha512_msg_pack
    import hmac512_pkg::*;
#(
    parameter int InW  = InWDef,
    parameter int OutW = OutWDef,
    parameter int LenW = LenWDef
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              sha_en,
    input  logic              hash_start,
    input  logic              hash_process,
    input  logic              hash_done,
    input  logic              in_valid,
    input  logic [InW-1:0]    in_data,
    input  logic [InW/8-1:0]  in_strb,
    output logic              in_ready,
    output logic              fifo_wvalid,
    output logic [OutW-1:0]   fifo_wdata,
    output logic [OutW/8-1:0] fifo_wmask,
    input  logic              fifo_wready,
    output logic [LenW-1:0]   message_length,
    output logic              flush_done,
    output logic              err_strb
);

    localparam int AccW = OutW - 8;

    pack_st_e          state_q, state_d;
    logic [AccW-1:0]   acc_q, acc_d;
    cnt_t              acc_cnt_q, acc_cnt_d;
    logic              ovalid_q, ovalid_d;
    logic [OutW-1:0]   odata_q, odata_d;
    logic [OutW/8-1:0] omask_q, omask_d;
    logic [LenW-1:0]   len_q, len_d;
    logic              flush_done_q, flush_done_d;
    logic              err_strb_q, err_strb_d;

    strb_dec_t         dec;
    logic              accept;
    logic [OutW-1:0]   m_word;
    logic              m_full;
    logic [AccW-1:0]   m_rem;
    cnt_t              m_cnt;

    assign dec      = strb_decode(in_strb);
    assign in_ready = (state_q == StPack) && (!ovalid_q || fifo_wready);
    assign accept   = in_valid && in_ready;

    sha512_byte_merge #(
        .InW  (InW),
        .OutW (OutW)
    ) u_merge (
        .acc_i     (acc_q),
        .acc_cnt_i (acc_cnt_q),
        .data_i    (in_data),
        .n_i       (dec.cnt),
        .word_o    (m_word),
        .full_o    (m_full),
        .rem_o     (m_rem),
        .cnt_o     (m_cnt)
    );

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        acc_cnt_d    = acc_cnt_q;
        ovalid_d     = ovalid_q && !fifo_wready;
        odata_d      = odata_q;
        omask_d      = omask_q;
        len_d        = len_q;
        flush_done_d = 1'b0;
        err_strb_d   = 1'b0;

        if (!sha_en) begin
            state_d   = StIdle;
            acc_d     = '0;
            acc_cnt_d = '0;
            ovalid_d  = 1'b0;
            odata_d   = '0;
            omask_d   = '0;
        end else if (hash_start) begin
            state_d   = StPack;
            acc_d     = '0;
            acc_cnt_d = '0;
            ovalid_d  = 1'b0;
            odata_d   = '0;
            omask_d   = '0;
            len_d     = '0;
        end else begin
            case (state_q)
                StPack: begin
                    if (accept) begin
                        if (dec.invalid) begin
                            err_strb_d = 1'b1;
                        end else begin
                            acc_d     = m_rem;
                            acc_cnt_d = m_cnt;
                            len_d     = len_q + LenW'({dec.cnt, 3'b000});
                            if (m_full) begin
                                ovalid_d = 1'b1;
                                odata_d  = m_word;
                                omask_d  = '1;
                            end
                        end
                    end
                    if (hash_process) begin
                        state_d = StFlush;
                    end
                end
                StFlush: begin
                    if (!ovalid_q) begin
                        if (acc_cnt_q != '0) begin
                            ovalid_d  = 1'b1;
                            odata_d   = {acc_q, 8'h00};
                            omask_d   = mask_from_cnt(acc_cnt_q);
                            acc_d     = '0;
                            acc_cnt_d = '0;
                        end else begin
                            flush_done_d = 1'b1;
                            state_d      = StDone;
                        end
                    end
                end
                StDone: begin
                    if (hash_done) begin
                        state_d = StIdle;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            ovalid_q     <= 1'b0;
            odata_q      <= '0;
            omask_q      <= '0;
            len_q        <= '0;
            flush_done_q <= 1'b0;
            err_strb_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            ovalid_q     <= ovalid_d;
            odata_q      <= odata_d;
            omask_q      <= omask_d;
            len_q        <= len_d;
            flush_done_q <= flush_done_d;
            err_strb_q   <= err_strb_d;
        end
    end

    assign fifo_wvalid    = ovalid_q;
    assign fifo_wdata     = odata_q;
    assign fifo_wmask     = omask_q;
    assign message_length = len_q;
    assign flush_done     = flush_done_q;
    assign err_strb       = err_strb_q;

endmodule

// File: tb/tb_sha512_msg_pack.sv
// Directed and randomized bench for sha512_msg_pack against a byte-queue model of
// the message stream.
module tb_sha512_msg_pack;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         sha_en;
    logic         hash_start;
    logic         hash_process;
    logic         hash_done;
    logic         in_valid;
    logic [31:0]  in_data;
    logic [3:0]   in_strb;
    logic         in_ready;
    logic         fifo_wvalid;
    logic [63:0]  fifo_wdata;
    logic [7:0]   fifo_wmask;
    logic         fifo_wready;
    logic [127:0] message_length;
    logic         flush_done;
    logic         err_strb;

    int checks = 0;
    int failures = 0;

    logic [7:0]   bq[$];
    logic [71:0]  exp_q[$];
    logic [71:0]  obs_q[$];
    logic [127:0] exp_len = '0;
    int           exp_err = 0;
    int           exp_flush = 0;
    int           err_cnt = 0;
    int           flush_cnt = 0;

    logic [3:0]   legal_tab[5] = '{4'h0, 4'h8, 4'hC, 4'hE, 4'hF};
    logic [3:0]   bad_tab[3]   = '{4'h5, 4'h6, 4'h1};

    sha512_msg_pack dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .sha_en         (sha_en),
        .hash_start     (hash_start),
        .hash_process   (hash_process),
        .hash_done      (hash_done),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_strb        (in_strb),
        .in_ready       (in_ready),
        .fifo_wvalid    (fifo_wvalid),
        .fifo_wdata     (fifo_wdata),
        .fifo_wmask     (fifo_wmask),
        .fifo_wready    (fifo_wready),
        .message_length (message_length),
        .flush_done     (flush_done),
        .err_strb       (err_strb)
    );

    always #5 clk_i = ~clk_i;

    always @(negedge clk_i) begin
        if (fifo_wvalid && fifo_wready) obs_q.push_back({fifo_wdata, fifo_wmask});
        if (flush_done) flush_cnt++;
        if (err_strb) err_cnt++;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int legal_n(input logic [3:0] s);
        case (s)
            4'h0: return 0;
            4'h8: return 1;
            4'hC: return 2;
            4'hE: return 3;
            4'hF: return 4;
            default: return -1;
        endcase
    endfunction

    task automatic model_beat(input logic [31:0] d, input logic [3:0] s);
        int n;
        logic [71:0] e;
        n = legal_n(s);
        if (n < 0) begin
            exp_err++;
        end else begin
            for (int i = 0; i < n; i++) bq.push_back(d[31-8*i -: 8]);
            exp_len = exp_len + 128'(8 * n);
            while (bq.size() >= 8) begin
                e = '0;
                for (int j = 0; j < 8; j++) e[71-8*j -: 8] = bq.pop_front();
                e[7:0] = 8'hFF;
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic model_flush();
        logic [71:0] e;
        if (bq.size() > 0) begin
            e = '0;
            for (int j = 0; j < bq.size(); j++) begin
                e[71-8*j -: 8] = bq[j];
                e[7-j] = 1'b1;
            end
            exp_q.push_back(e);
            bq.delete();
        end
        exp_flush++;
    endtask

    task automatic model_clear();
        bq.delete();
        exp_q.delete();
        exp_len = '0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic start_msg();
        hash_start = 1'b1;
        step();
        hash_start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s, input bit proc);
        bit got = 1'b0;
        in_valid = 1'b1;
        in_data = d;
        in_strb = s;
        hash_process = proc;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk_i);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
            step();
            if (k >= 2) fifo_wready = 1'b1;
        end
        chk("beat_accepted", 128'(got), 128'(1));
        step();
        in_valid = 1'b0;
        hash_process = 1'b0;
        if (got) model_beat(d, s);
    endtask

    task automatic wait_flush();
        bit got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_i);
            if (flush_done) begin
                got = 1'b1;
                break;
            end
        end
        chk("flush_done_seen", 128'(got), 128'(1));
        model_flush();
        step();
    endtask

    task automatic end_msg();
        hash_process = 1'b1;
        step();
        hash_process = 1'b0;
        wait_flush();
    endtask

    task automatic check_msg(input string tag);
        int n;
        chk({tag, "_entry_count"}, 128'(obs_q.size()), 128'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk({tag, "_entry"}, 128'(obs_q[i]), 128'(exp_q[i]));
        chk({tag, "_length"}, message_length, exp_len);
        chk({tag, "_flush_count"}, 128'(flush_cnt), 128'(exp_flush));
        chk({tag, "_err_count"}, 128'(err_cnt), 128'(exp_err));
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic close_msg();
        hash_done = 1'b1;
        step();
        hash_done = 1'b0;
    endtask

    initial begin
        logic [3:0] s;
        int r;
        rst_i = 1'b1;
        sha_en = 1'b0;
        hash_start = 1'b0;
        hash_process = 1'b0;
        hash_done = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        in_strb = '0;
        fifo_wready = 1'b1;
        repeat (2) step();

        chk("rst_wvalid", 128'(fifo_wvalid), 128'(0));
        chk("rst_wdata", 128'(fifo_wdata), 128'(0));
        chk("rst_wmask", 128'(fifo_wmask), 128'(0));
        chk("rst_length", message_length, 128'(0));
        chk("rst_flush_done", 128'(flush_done), 128'(0));
        chk("rst_err_strb", 128'(err_strb), 128'(0));
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        rst_i = 1'b0;
        sha_en = 1'b1;
        step();
        chk("idle_in_ready", 128'(in_ready), 128'(0));

        // aligned stream
        start_msg();
        chk("pack_in_ready", 128'(in_ready), 128'(1));
        send(32'h00010203, 4'hF, 0);
        send(32'h04050607, 4'hF, 0);
        send(32'h08090A0B, 4'hF, 0);
        end_msg();
        chk("aligned_count", 128'(obs_q.size()), 128'(2));
        chk("aligned_e0", 128'(obs_q[0]), 128'(72'h0001020304050607FF));
        chk("aligned_e1", 128'(obs_q[1]), 128'(72'h08090A0B00000000F0));
        chk("aligned_len", message_length, 128'(96));
        check_msg("aligned");
        repeat (3) step();
        chk("done_in_ready", 128'(in_ready), 128'(0));
        chk("done_len_hold", message_length, 128'(96));
        chk("done_single_flush", 128'(flush_cnt), 128'(1));
        close_msg();

        // unaligned stream
        start_msg();
        send(32'hAABB0000, 4'hC, 0);
        send(32'h11223344, 4'hF, 0);
        send(32'h55667788, 4'hF, 0);
        end_msg();
        chk("unaligned_count", 128'(obs_q.size()), 128'(2));
        chk("unaligned_e0", 128'(obs_q[0]), 128'(72'hAABB112233445566FF));
        chk("unaligned_e1", 128'(obs_q[1]), 128'(72'h7788000000000000C0));
        chk("unaligned_len", message_length, 128'(80));
        check_msg("unaligned");
        close_msg();

        // backpressure: out register full with fifo_wready low
        start_msg();
        fifo_wready = 1'b0;
        send($urandom, 4'hF, 0);
        send($urandom, 4'hF, 0);
        in_valid = 1'b1;
        in_data = 32'hC0DEC0DE;
        in_strb = 4'hF;
        repeat (5) begin
            @(negedge clk_i);
            chk("bp_in_ready_low", 128'(in_ready), 128'(0));
            chk("bp_wvalid_held", 128'(fifo_wvalid), 128'(1));
            chk("bp_wdata_held", 128'({fifo_wdata, fifo_wmask}), 128'(exp_q[0]));
            step();
        end
        fifo_wready = 1'b1;
        send(32'hC0DEC0DE, 4'hF, 0);
        for (int i = 0; i < 5; i++) send($urandom, 4'hF, 0);
        end_msg();
        chk("bp_len", message_length, 128'(8 * 4 * 8));
        check_msg("backpressure");
        close_msg();

        // illegal strobe mid-stream
        start_msg();
        send($urandom, 4'hF, 0);
        send($urandom, 4'hE, 0);
        send(32'hDEADBEEF, 4'h5, 0);
        send($urandom, 4'hC, 0);
        send($urandom, 4'hF, 0);
        end_msg();
        chk("illegal_len", message_length, 128'(8 * 13));
        check_msg("illegal");
        close_msg();

        // exactly 16 bytes: no partial entry
        start_msg();
        for (int i = 0; i < 4; i++) send($urandom, 4'hF, 0);
        end_msg();
        chk("exact16_count", 128'(obs_q.size()), 128'(2));
        check_msg("exact16");
        repeat (4) step();
        chk("exact16_done_ready", 128'(in_ready), 128'(0));
        chk("exact16_no_entry", 128'(fifo_wvalid), 128'(0));
        close_msg();

        // randomized stream with backpressure and a final beat alongside hash_process
        start_msg();
        for (int i = 0; i < 40; i++) begin
            fifo_wready = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            s = (r >= 8) ? bad_tab[r % 3] : legal_tab[r % 5];
            send($urandom, s, 0);
        end
        fifo_wready = 1'b1;
        send($urandom, legal_tab[$urandom_range(1, 4)], 1);
        wait_flush();
        check_msg("random");
        close_msg();

        // restart while an entry is pending and 3 bytes are buffered
        start_msg();
        fifo_wready = 1'b0;
        send($urandom, 4'hE, 0);
        send($urandom, 4'hF, 0);
        send($urandom, 4'hF, 0);
        chk("restart_pending", 128'(fifo_wvalid), 128'(1));
        start_msg();
        @(negedge clk_i);
        chk("restart_wvalid", 128'(fifo_wvalid), 128'(0));
        chk("restart_len", message_length, 128'(0));
        chk("restart_no_handshake", 128'(obs_q.size()), 128'(0));
        step();
        fifo_wready = 1'b1;
        send(32'h01020304, 4'hF, 0);
        send(32'h05060708, 4'hF, 0);
        send(32'h090A0000, 4'hC, 0);
        end_msg();
        chk("restart_e0", 128'(obs_q[0]), 128'(72'h0102030405060708FF));
        check_msg("restart");
        close_msg();

        // asynchronous reset while flushing
        start_msg();
        fifo_wready = 1'b0;
        send($urandom, 4'hE, 0);
        send($urandom, 4'hF, 0);
        send($urandom, 4'hF, 0);
        hash_process = 1'b1;
        step();
        hash_process = 1'b0;
        step();
        #2;
        rst_i = 1'b1;
        #1;
        chk("arst_wvalid", 128'(fifo_wvalid), 128'(0));
        chk("arst_wdata", 128'(fifo_wdata), 128'(0));
        chk("arst_wmask", 128'(fifo_wmask), 128'(0));
        chk("arst_length", message_length, 128'(0));
        chk("arst_flush_done", 128'(flush_done), 128'(0));
        chk("arst_in_ready", 128'(in_ready), 128'(0));
        model_clear();
        step();
        rst_i = 1'b0;
        fifo_wready = 1'b1;
        repeat (5) step();
        chk("arst_no_entry", 128'(obs_q.size()), 128'(0));
        chk("arst_no_flush", 128'(flush_cnt), 128'(exp_flush));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
